// File: rtl/unit_pkg.sv
// Shared types and field-size constants for the unit motion stage.
package unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ENGAGE = 2'd2
    } mover_state_t;

    localparam int FIELD_X_W = 10;
    localparam int FIELD_Y_W = 10;

endpackage

// File: rtl/axis_stepper.sv
// One coordinate axis: clamped single step toward the target, plus range test.
module axis_stepper #(
    parameter int W     = 10,
    parameter int STEP  = 1,
    parameter int RANGE = 16
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] next_pos,
    output logic         near
);

    localparam logic [W:0] STEP_V  = (W+1)'(STEP);
    localparam logic [W:0] RANGE_V = (W+1)'(RANGE);

    logic signed [W:0] diff;
    logic        [W:0] mag;
    logic        [W:0] step;

    // Step is the smaller of STEP and the remaining distance, so the
    // position lands exactly on the target instead of overshooting.
    always_comb begin
        diff     = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        mag      = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        step     = (mag < STEP_V) ? mag : STEP_V;
        next_pos = diff[W] ? (pos - step[W-1:0]) : (pos + step[W-1:0]);
        near     = (mag <= RANGE_V);
    end

endmodule

// File: rtl/unit_mover.sv
// Single-unit motion FSM: walk toward the target on pacing ticks, then
// convert ticks into hit pulses while the target stays within range.
import unit_pkg::*;

module unit_mover #(
    parameter int X_W   = FIELD_X_W,
    parameter int Y_W   = FIELD_Y_W,
    parameter int STEP  = 1,
    parameter int RANGE = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spawn,
    input  logic [X_W-1:0] spawn_x,
    input  logic [Y_W-1:0] spawn_y,
    input  logic [X_W-1:0] target_x,
    input  logic [Y_W-1:0] target_y,
    input  logic           step_tick,
    input  logic           kill,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           alive,
    output logic           moving,
    output logic           in_range,
    output logic           arrived,
    output logic           hit
);

    mover_state_t   state_q, state_d;
    logic [X_W-1:0] pos_x_d, step_x;
    logic [Y_W-1:0] pos_y_d, step_y;
    logic           arrived_d, hit_d;
    logic           near_x, near_y;

    axis_stepper #(.W(X_W), .STEP(STEP), .RANGE(RANGE)) u_axis_x (
        .pos      (pos_x),
        .tgt      (target_x),
        .next_pos (step_x),
        .near     (near_x)
    );

    axis_stepper #(.W(Y_W), .STEP(STEP), .RANGE(RANGE)) u_axis_y (
        .pos      (pos_y),
        .tgt      (target_y),
        .next_pos (step_y),
        .near     (near_y)
    );

    assign in_range = near_x & near_y;
    assign alive    = (state_q != IDLE);
    assign moving   = (state_q == MOVE);

    // Next-state and pulse decode; kill beats spawn beats normal operation.
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x;
        pos_y_d   = pos_y;
        arrived_d = 1'b0;
        hit_d     = 1'b0;
        if (kill) begin
            state_d = IDLE;
        end else if (spawn) begin
            pos_x_d = spawn_x;
            pos_y_d = spawn_y;
            state_d = MOVE;
        end else begin
            case (state_q)
                MOVE: begin
                    // Range is checked every cycle, so arrival never waits for a tick.
                    if (in_range) begin
                        state_d   = ENGAGE;
                        arrived_d = 1'b1;
                    end else if (step_tick) begin
                        pos_x_d = step_x;
                        pos_y_d = step_y;
                    end
                end
                ENGAGE: begin
                    if (!in_range) state_d = MOVE;
                    else if (step_tick) hit_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, position and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_x   <= '0;
            pos_y   <= '0;
            arrived <= 1'b0;
            hit     <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x   <= pos_x_d;
            pos_y   <= pos_y_d;
            arrived <= arrived_d;
            hit     <= hit_d;
        end
    end

endmodule
